// File: rtl/uart_out_arbiter_pkg.sv
// Shared state encoding, constants and index helper for the UART transmit-port arbiter.
package uart_out_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam logic [7:0] DEFAULT_EOL = 8'h0A;
  localparam int         IDX_W       = 2;

  // Next round-robin start position: the slot after idx, wrapping at nreq.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int nreq);
    return (int'(idx) == nreq - 1) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/uart_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping at NREQ.
module rr_pick
  import uart_out_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0] w_rot;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit then wins.
  assign w_rot = NREQ'({req, req} >> ptr);

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign gnt = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/uart_out_arbiter.sv
// Shares one UART TX character port between NREQ requesters with round-robin
// arbitration and per-line locking; back-pressures instead of dropping characters.
module uart_out_arbiter
  import uart_out_arbiter_pkg::*;
#(
  parameter int         NREQ         = 2,
  parameter int         LOCK_TIMEOUT = 64,
  parameter logic [7:0] EOL_CHAR     = DEFAULT_EOL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_char,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        uart_io_char,
  output logic              uart_io_we,
  input  logic              uart_io_full,
  output logic              lock_active,
  output logic [1:0]        owner
);

  localparam int               CNT_W    = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam bit               LOCK_EN  = (LOCK_TIMEOUT > 0);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [7:0]       r_char;
  logic             r_we;

  logic             w_can_send;
  logic [NREQ-1:0]  w_pick_gnt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [NREQ-1:0]  w_owner_oh;
  logic             w_owner_valid;
  logic [NREQ-1:0]  w_grant;
  logic             w_accept;
  logic [7:0]       w_char;
  logic             w_is_eol;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // The strobe cycle itself blocks a grant, which also hides the full flag's one-cycle lag.
  assign w_can_send    = ~uart_io_full & ~r_we;
  assign w_owner_oh    = NREQ'(1) << r_owner;
  assign w_owner_valid = |(req_valid & w_owner_oh);

  always_comb begin
    w_grant = '0;
    if (!rst && w_can_send) begin
      if (r_state == ARB_LOCK)
        w_grant = req_valid & w_owner_oh;
      else if (w_pick_any)
        w_grant = w_pick_gnt;
    end
  end

  always_comb begin
    w_char = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) w_char = req_char[8*i +: 8];
  end

  assign w_accept = |w_grant;
  assign w_is_eol = (w_char == EOL_CHAR);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
      r_char     <= '0;
      r_we       <= 1'b0;
    end else begin
      r_we <= w_accept;
      if (w_accept) r_char <= w_char;

      case (r_state)
        ARB_IDLE: begin
          if (w_accept) begin
            r_owner    <= w_pick_idx;
            r_rr_ptr   <= rr_next(w_pick_idx, NREQ);
            r_idle_cnt <= '0;
            r_state    <= (w_is_eol || !LOCK_EN) ? ARB_IDLE : ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          // Only an absent owner counts as idle; stalling on a full FIFO does not.
          if (w_owner_valid) begin
            r_idle_cnt <= '0;
            if (w_accept && w_is_eol) r_state <= ARB_IDLE;
          end else if (r_idle_cnt == CNT_LAST) begin
            r_idle_cnt <= '0;
            r_state    <= ARB_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign req_ready    = w_grant;
  assign uart_io_char = r_char;
  assign uart_io_we   = r_we;
  assign lock_active  = (r_state == ARB_LOCK);
  assign owner        = 2'(r_owner);

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Bench for uart_out_arbiter: one locking instance (timeout 4) and one per-character
// round-robin instance (timeout 0), checked every cycle against a line-level model.
module tb_uart_out_arbiter;

  localparam int         NI  = 2;
  localparam logic [7:0] EOL = 8'h0A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst   [NI];
  logic        s_full  [NI];
  logic [1:0]  s_valid [NI];
  logic [15:0] s_char  [NI];
  logic [1:0]  w_ready [NI];
  logic [7:0]  w_char  [NI];
  logic        w_we    [NI];
  logic        w_lock  [NI];
  logic [1:0]  w_owner [NI];

  uart_out_arbiter #(.NREQ(2), .LOCK_TIMEOUT(4), .EOL_CHAR(8'h0A)) u_dut_lock (
    .clk(clk), .rst(s_rst[0]), .req_valid(s_valid[0]), .req_char(s_char[0]),
    .req_ready(w_ready[0]), .uart_io_char(w_char[0]), .uart_io_we(w_we[0]),
    .uart_io_full(s_full[0]), .lock_active(w_lock[0]), .owner(w_owner[0]));

  uart_out_arbiter #(.NREQ(2), .LOCK_TIMEOUT(0), .EOL_CHAR(8'h0A)) u_dut_nolock (
    .clk(clk), .rst(s_rst[1]), .req_valid(s_valid[1]), .req_char(s_char[1]),
    .req_ready(w_ready[1]), .uart_io_char(w_char[1]), .uart_io_we(w_we[1]),
    .uart_io_full(s_full[1]), .lock_active(w_lock[1]), .owner(w_owner[1]));

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // Requester character streams
  logic [7:0] txbuf [NI][2][16];
  int         head  [NI][2];
  int         tail  [NI][2];
  bit         acc   [NI][2];

  // Line-level model state and write log
  bit         m_lock  [NI];
  int         m_owner [NI];
  int         m_rr    [NI];
  int         m_idle  [NI];
  bit         m_we    [NI];
  logic [7:0] m_char  [NI];
  logic [7:0] wlog  [NI][32];
  int         wcyc  [NI][32];
  bit         wlock [NI][32];
  int         wcnt  [NI];
  int         cyc;
  int         n_cmp;
  int         n_bad;
  bit         started;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int         cand;
    bit         can;
    logic [1:0] exp_rdy;
    logic [7:0] c;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      can  = !s_full[k] && !m_we[k];
      cand = -1;
      if (m_lock[k]) begin
        if (s_valid[k][m_owner[k]]) cand = m_owner[k];
      end else begin
        for (int i = 0; i < 2; i++)
          if (cand < 0 && s_valid[k][(m_rr[k] + i) % 2]) cand = (m_rr[k] + i) % 2;
      end
      exp_rdy = 2'b00;
      if (!s_rst[k] && can && cand >= 0) exp_rdy[cand] = 1'b1;
      c = (cand == 1) ? s_char[k][15:8] : s_char[k][7:0];

      if (started) begin
        check($sformatf("ready[%0d]", k), w_ready[k], exp_rdy);
        check($sformatf("we[%0d]", k), w_we[k], m_we[k]);
        check($sformatf("lock[%0d]", k), w_lock[k], m_lock[k]);
        check($sformatf("owner[%0d]", k), w_owner[k], m_owner[k]);
        if (m_we[k]) check($sformatf("char[%0d]", k), w_char[k], m_char[k]);
        if (w_we[k] === 1'b1) begin
          if (wcnt[k] < 32) begin
            wlog[k][wcnt[k]]  = w_char[k];
            wcyc[k][wcnt[k]]  = cyc;
            wlock[k][wcnt[k]] = w_lock[k];
          end
          wcnt[k]++;
        end
      end
      for (int r = 0; r < 2; r++) acc[k][r] = w_ready[k][r] & s_valid[k][r];

      if (s_rst[k]) begin
        m_lock[k] = 0; m_owner[k] = 0; m_rr[k] = 0; m_idle[k] = 0; m_we[k] = 0; m_char[k] = 8'h00;
      end else begin
        m_we[k] = (exp_rdy != 2'b00);
        if (m_we[k]) m_char[k] = c;
        if (!m_lock[k]) begin
          if (m_we[k]) begin
            m_owner[k] = cand;
            m_rr[k]    = (cand + 1) % 2;
            m_lock[k]  = (c != EOL) && (tmo(k) > 0);
            m_idle[k]  = 0;
          end
        end else if (s_valid[k][m_owner[k]]) begin
          m_idle[k] = 0;
          if (m_we[k] && c == EOL) m_lock[k] = 0;
        end else begin
          m_idle[k]++;
          if (m_idle[k] == tmo(k)) begin
            m_lock[k] = 0;
            m_idle[k] = 0;
          end
        end
      end
    end
  end

  task automatic drive();
    for (int k = 0; k < NI; k++)
      for (int r = 0; r < 2; r++) begin
        s_valid[k][r]      = (head[k][r] < tail[k][r]);
        s_char[k][8*r +: 8] = txbuf[k][r][head[k][r] % 16];
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      for (int r = 0; r < 2; r++)
        if (acc[k][r]) head[k][r]++;
    drive();
  endtask

  task automatic load(input int k, input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      txbuf[k][r][tail[k][r] % 16] = s[i];
      tail[k][r]++;
    end
  endtask

  task automatic begin_test(input int k);
    s_rst[k]  = 1'b1;
    s_full[k] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      head[k][r] = 0;
      tail[k][r] = 0;
    end
    drive();
    tick();
  endtask

  task automatic release_rst(input int k);
    s_rst[k] = 1'b0;
    drive();
  endtask

  task automatic wait_writes(input int k, input int n, input int budget, input string name);
    int b;
    b = 0;
    while (wcnt[k] < n && b < budget) begin
      tick();
      b++;
    end
    check({name, " write count"}, wcnt[k], n);
  endtask

  initial begin
    int    base;
    int    c0;
    int    b;
    string exp_s;
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < NI; k++) begin
      s_rst[k]  = 1'b1;
      s_full[k] = 1'b0;
    end
    drive();
    tick();
    started = 1'b1;

    // 1: single requester, "AB\n", 2-cycle strobe spacing, lock drops after EOL
    begin_test(0);
    base = wcnt[0];
    load(0, 0, "AB\n");
    release_rst(0);
    wait_writes(0, base + 3, 40, "t1");
    check("t1 char0", wlog[0][base], 8'h41);
    check("t1 char1", wlog[0][base+1], 8'h42);
    check("t1 char2", wlog[0][base+2], 8'h0A);
    check("t1 gap0", wcyc[0][base+1] - wcyc[0][base], 2);
    check("t1 gap1", wcyc[0][base+2] - wcyc[0][base+1], 2);
    check("t1 lock during line", wlock[0][base+1], 1);
    check("t1 lock after EOL", wlock[0][base+2], 0);

    // 2: two lines offered together, no interleave
    begin_test(0);
    base = wcnt[0];
    load(0, 0, "ab\n");
    load(0, 1, "cd\n");
    release_rst(0);
    wait_writes(0, base + 6, 60, "t2");
    exp_s = "ab\ncd\n";
    for (int i = 0; i < 6; i++)
      check($sformatf("t2 char%0d", i), wlog[0][base+i], exp_s[i]);

    // 3: FIFO full for 10 cycles in IDLE, then released
    begin_test(0);
    s_full[0] = 1'b1;
    load(0, 0, "U");
    release_rst(0);
    base = wcnt[0];
    repeat (10) tick();
    check("t3 no write while full", wcnt[0], base);
    c0 = cyc;
    s_full[0] = 1'b0;
    drive();
    wait_writes(0, base + 1, 10, "t3");
    check("t3 char", wlog[0][base], 8'h55);
    check("t3 latency", wcyc[0][base] - c0, 2);
    repeat (10) tick();
    check("t3 written once", wcnt[0], base + 1);

    // 3b: FIFO full while the owner stays valid keeps the lock
    begin_test(0);
    base = wcnt[0];
    load(0, 0, "P");
    release_rst(0);
    wait_writes(0, base + 1, 10, "t3b");
    s_full[0] = 1'b1;
    load(0, 0, "Q");
    drive();
    repeat (10) tick();
    check("t3b lock held", w_lock[0], 1);
    s_full[0] = 1'b0;
    drive();
    wait_writes(0, base + 2, 10, "t3b");
    check("t3b char", wlog[0][base+1], 8'h51);

    // 4: lock timeout after 4 idle cycles, then req1 in the first IDLE cycle
    begin_test(0);
    base = wcnt[0];
    load(0, 0, "x");
    load(0, 1, "y");
    release_rst(0);
    wait_writes(0, base + 2, 40, "t4");
    check("t4 char0", wlog[0][base], 8'h78);
    check("t4 char1", wlog[0][base+1], 8'h79);
    check("t4 gap", wcyc[0][base+1] - wcyc[0][base], 5);
    check("t4 new owner", w_owner[0], 1);

    // 5: no-lock instance alternates per character
    begin_test(1);
    base = wcnt[1];
    load(1, 0, "0123");
    load(1, 1, "abcd");
    release_rst(1);
    wait_writes(1, base + 8, 60, "t5");
    exp_s = "0a1b2c3d";
    for (int i = 0; i < 8; i++)
      check($sformatf("t5 char%0d", i), wlog[1][base+i], exp_s[i]);

    // 6: reset while locked with the strobe high
    begin_test(0);
    base = wcnt[0];
    load(0, 0, "mn");
    load(0, 1, "z");
    release_rst(0);
    b = 0;
    while (w_we[0] !== 1'b1 && b < 10) begin
      tick();
      b++;
    end
    check("t6 we before rst", w_we[0], 1);
    check("t6 lock before rst", w_lock[0], 1);
    s_rst[0] = 1'b1;
    drive();
    tick();
    check("t6 we after rst", w_we[0], 0);
    check("t6 lock after rst", w_lock[0], 0);
    check("t6 owner after rst", w_owner[0], 0);
    release_rst(0);
    wait_writes(0, base + 3, 60, "t6");
    exp_s = "mnz";
    for (int i = 0; i < 3; i++)
      check($sformatf("t6 char%0d", i), wlog[0][base+i], exp_s[i]);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
